// File: rtl/msk_key_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msk_key_load_ctrl_pkg
// Brief    : Shared state encodings and sizing helpers for the key-load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package msk_key_load_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t c_st_idle  = 3'd0;
  localparam state_t c_st_prst  = 3'd1;
  localparam state_t c_st_seed  = 3'd2;
  localparam state_t c_st_key   = 3'd3;
  localparam state_t c_st_waitr = 3'd4;
  localparam state_t c_st_ready = 3'd5;
  localparam state_t c_st_rfsh  = 3'd6;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width able to index 0..n-1, never narrower than one bit
  function automatic int f_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_key_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : msk_key_load_ctrl_if
// Brief    : Host handshake plus downstream control bundle of the key-load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface msk_key_load_ctrl_if #(
  parameter int SIZE_FEED = 32
);
  logic                 start;
  logic [SIZE_FEED-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 refresh_req;
  logic                 pre_rst;
  logic [SIZE_FEED-1:0] data_in;
  logic                 data_in_valid;
  logic                 feed_prng_seed;
  logic                 n_lock_for_seed;
  logic                 rnd_ready;
  logic                 pre_pre_refresh;
  logic                 key_ready;

  modport master (
    output start, in_data, in_valid, refresh_req, rnd_ready,
    input  in_ready, pre_rst, data_in, data_in_valid, feed_prng_seed,
           n_lock_for_seed, pre_pre_refresh, key_ready
  );

  modport slave (
    input  start, in_data, in_valid, refresh_req, rnd_ready,
    output in_ready, pre_rst, data_in, data_in_valid, feed_prng_seed,
           n_lock_for_seed, pre_pre_refresh, key_ready
  );
endinterface
`default_nettype wire

// File: rtl/msk_key_load_ctrl_word_counter.sv
`default_nettype none
// ============================================================================
// Module   : msk_key_load_ctrl_word_counter
// Brief    : Up-counter that returns to zero on reaching a run-time limit.
// Revision : 1.0 - initial release
// ============================================================================
module msk_key_load_ctrl_word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_terminal
);
  logic [WIDTH-1:0] r_count;

  assign o_terminal = (r_count == i_limit);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr || (i_en && o_terminal)) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/msk_key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msk_key_load_ctrl
// Brief    : Sequences PRNG reset, seed and key-share loading and key refresh
//            for the downstream masked key holder.
// Revision : 1.0 - initial release
// ============================================================================
module msk_key_load_ctrl
  import msk_key_load_ctrl_pkg::*;
#(
  parameter int d          = 2,
  parameter int Nbits      = 128,
  parameter int SIZE_FEED  = 32,
  parameter int SEED_WORDS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  msk_key_load_ctrl_if.slave bus
);
  localparam int c_key_words = (d * Nbits) / SIZE_FEED;
  localparam int c_cnt_w     = f_cnt_width(f_max(SEED_WORDS, c_key_words));
  localparam logic [c_cnt_w-1:0] c_seed_last = c_cnt_w'(SEED_WORDS - 1);
  localparam logic [c_cnt_w-1:0] c_key_last  = c_cnt_w'(c_key_words - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rnd_dropped;
  logic                 r_pre_pre_refresh;
  logic                 w_refresh_fire;
  logic [SIZE_FEED-1:0] r_data_in;
  logic                 r_data_in_valid;
  logic                 r_feed_prng_seed;
  logic                 w_loading;
  logic                 w_hs;
  logic                 w_cnt_term;
  logic [c_cnt_w-1:0]   w_cnt_limit;

  assign w_loading   = (r_state == c_st_seed) || (r_state == c_st_key);
  assign w_hs        = bus.in_valid && w_loading;
  assign w_cnt_limit = (r_state == c_st_seed) ? c_seed_last : c_key_last;

  msk_key_load_ctrl_word_counter #(
    .WIDTH (c_cnt_w)
  ) u_word_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_en       (w_hs),
    .i_clr      (r_state == c_st_prst),
    .i_limit    (w_cnt_limit),
    .o_terminal (w_cnt_term)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_refresh_fire = 1'b0;
    case (r_state)
      c_st_idle:  if (bus.start) w_state_nxt = c_st_prst;
      c_st_prst:  w_state_nxt = c_st_seed;
      c_st_seed:  if (w_hs && w_cnt_term) w_state_nxt = c_st_key;
      c_st_key:   if (w_hs && w_cnt_term) w_state_nxt = c_st_waitr;
      c_st_waitr: if (bus.rnd_ready) w_state_nxt = c_st_ready;
      c_st_ready: begin
        // A reload takes priority; the simultaneous refresh request is dropped
        if (bus.start) begin
          w_state_nxt = c_st_prst;
        end else if (bus.refresh_req) begin
          w_state_nxt    = c_st_rfsh;
          w_refresh_fire = 1'b1;
        end
      end
      c_st_rfsh:  if (r_rnd_dropped && bus.rnd_ready) w_state_nxt = c_st_ready;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state           <= c_st_idle;
      r_pre_pre_refresh <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_pre_pre_refresh <= w_refresh_fire;
    end
  end

  // Randomness counts as fresh only after a low-then-high on rnd_ready
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rnd_dropped <= 1'b0;
    end else if (r_state != c_st_rfsh) begin
      r_rnd_dropped <= 1'b0;
    end else if (!bus.rnd_ready) begin
      r_rnd_dropped <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_in        <= '0;
      r_data_in_valid  <= 1'b0;
      r_feed_prng_seed <= 1'b0;
    end else begin
      r_data_in_valid <= w_hs;
      if (w_hs) begin
        r_data_in        <= bus.in_data;
        r_feed_prng_seed <= (r_state == c_st_seed);
      end
    end
  end

  assign bus.in_ready        = w_loading;
  assign bus.pre_rst         = (r_state == c_st_prst);
  assign bus.n_lock_for_seed = (r_state == c_st_seed);
  assign bus.key_ready       = (r_state == c_st_ready);
  assign bus.pre_pre_refresh = r_pre_pre_refresh;
  assign bus.data_in         = r_data_in;
  assign bus.data_in_valid   = r_data_in_valid;
  assign bus.feed_prng_seed  = r_feed_prng_seed;
endmodule
`default_nettype wire

// File: tb/tb_msk_key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_key_load_ctrl
// Brief    : Self-checking bench for the key-load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_key_load_ctrl;
  localparam int SEED_WORDS = 4;
  localparam int TOTAL      = 12;
  localparam int OW         = 7 + 32;

  logic clk;
  logic n_rst;

  msk_key_load_ctrl_if #(.SIZE_FEED(32)) bus ();

  msk_key_load_ctrl #(
    .d          (2),
    .Nbits      (128),
    .SIZE_FEED  (32),
    .SEED_WORDS (SEED_WORDS)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {P_IDLE, P_PRST, P_LOAD, P_WAIT, P_READY, P_RFSH} phase_t;

  typedef struct {
    logic          start;
    logic          in_valid;
    logic          rnd_ready;
    logic          refresh_req;
    logic [31:0]   in_data;
    logic [OW-1:0] exp;
  } vec_t;

  int          n_total;
  int          n_bad;
  phase_t      m_phase;
  int          m_taken;
  bit          m_low_seen;
  bit          m_ppr;
  bit          m_valid;
  bit          m_seed;
  logic [31:0] m_data;
  logic [31:0] got[$];
  vec_t        tbl[$];

  task automatic m_reset();
    m_phase    = P_IDLE;
    m_taken    = 0;
    m_low_seen = 0;
    m_ppr      = 0;
    m_valid    = 0;
    m_seed     = 0;
    m_data     = '0;
  endtask

  // Phase-level reference: the whole load is one phase of TOTAL words,
  // the first SEED_WORDS of which are seed.
  task automatic model_edge();
    bit hs;
    hs      = bus.in_valid && (m_phase == P_LOAD);
    m_ppr   = 0;
    m_valid = hs;
    if (hs) begin
      m_data  = bus.in_data;
      m_seed  = (m_taken < SEED_WORDS);
      m_taken = m_taken + 1;
    end
    case (m_phase)
      P_IDLE:  if (bus.start) m_phase = P_PRST;
      P_PRST:  begin m_phase = P_LOAD; m_taken = 0; end
      P_LOAD:  if (m_taken == TOTAL) m_phase = P_WAIT;
      P_WAIT:  if (bus.rnd_ready) m_phase = P_READY;
      P_READY: begin
        if (bus.start) m_phase = P_PRST;
        else if (bus.refresh_req) begin
          m_phase = P_RFSH; m_ppr = 1; m_low_seen = 0;
        end
      end
      P_RFSH: begin
        if (m_low_seen && bus.rnd_ready) m_phase = P_READY;
        else if (!bus.rnd_ready) m_low_seen = 1;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  function automatic logic [OW-1:0] ev(input bit ir, input bit pr, input bit nl, input bit kr,
                                       input bit ppr, input bit v, input bit sd, input logic [31:0] dat);
    return {ir, pr, nl, kr, ppr, v, sd, dat};
  endfunction

  function automatic logic [OW-1:0] model_out();
    return ev(m_phase == P_LOAD, m_phase == P_PRST, (m_phase == P_LOAD) && (m_taken < SEED_WORDS),
              m_phase == P_READY, m_ppr, m_valid, m_seed, m_data);
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.in_ready, bus.pre_rst, bus.n_lock_for_seed, bus.key_ready, bus.pre_pre_refresh,
            bus.data_in_valid, bus.feed_prng_seed, bus.data_in};
  endfunction

  function automatic vec_t mk(input bit st, input bit iv, input bit rr, input bit rq,
                              input logic [31:0] dat, input logic [OW-1:0] e);
    vec_t v;
    v.start = st; v.in_valid = iv; v.rnd_ready = rr; v.refresh_req = rq;
    v.in_data = dat; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle_chk(input string name);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (bus.data_in_valid) got.push_back(bus.data_in);
    check(name, dut_out(), model_out());
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.refresh_req = 0; bus.rnd_ready = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    n_rst = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] words[TOTAL];
    int idx;
    int ppr_cnt;
    bit hs;

    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < TOTAL; i++)
      words[i] = (i < SEED_WORDS) ? 32'h1000 + i : 32'h2000 + (i - SEED_WORDS);

    // Directed vectors: full load, spurious inputs, refresh and start/refresh conflicts
    tbl.push_back(mk(1, 0, 0, 0, 32'h0, ev(0, 1, 0, 0, 0, 0, 0, 32'h0)));
    tbl.push_back(mk(0, 1, 0, 0, 32'h1000, ev(1, 0, 1, 0, 0, 0, 0, 32'h0)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 0, 32'h1000 + i, ev(1, 0, i < 3, 0, 0, 1, 1, 32'h1000 + i)));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 0, 0, 32'h2000 + i, ev(i < 7, 0, 0, 0, 0, 1, 0, 32'h2000 + i)));
    tbl.push_back(mk(0, 1, 1, 0, 32'hdead, ev(0, 0, 0, 1, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 1, 1, 0, 32'hbeef, ev(0, 0, 0, 1, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0, ev(0, 0, 0, 0, 1, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0, ev(0, 0, 0, 0, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0, ev(0, 0, 0, 0, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0, ev(0, 0, 0, 0, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0, ev(0, 0, 0, 1, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(1, 0, 1, 1, 32'h0, ev(0, 1, 0, 0, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, ev(1, 0, 1, 0, 0, 0, 0, 32'h2007)));
    tbl.push_back(mk(0, 1, 0, 1, 32'h3000, ev(1, 0, 1, 0, 0, 1, 1, 32'h3000)));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0, ev(1, 0, 1, 0, 0, 0, 1, 32'h3000)));

    idle_inputs();
    n_rst = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_vals", dut_out(), '0);
    n_rst = 1'b1;
    cycle_chk("idle_after_reset");

    for (int i = 0; i < tbl.size(); i++) begin
      bus.start       = tbl[i].start;
      bus.in_valid    = tbl[i].in_valid;
      bus.rnd_ready   = tbl[i].rnd_ready;
      bus.refresh_req = tbl[i].refresh_req;
      bus.in_data     = tbl[i].in_data;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of the key phase (after key word 3)
    apply_reset();
    bus.start = 1;
    cycle_chk("ar_start");
    bus.start = 0;
    cycle_chk("ar_prst");
    for (int i = 0; i < SEED_WORDS + 3; i++) begin
      bus.in_valid = 1; bus.in_data = words[i];
      cycle_chk("ar_load");
    end
    #2 n_rst = 1'b0;
    #1 check("async_reset_outputs", dut_out(), '0);
    m_reset();
    @(negedge clk);
    n_rst = 1'b1;
    bus.in_valid = 1; bus.in_data = 32'h5555;
    for (int i = 0; i < 5; i++) cycle_chk("ar_stay_idle");

    // Load with random gaps on in_valid; every word must appear once, in order
    apply_reset();
    bus.start = 1;
    cycle_chk("gap_start");
    bus.start = 0;
    got.delete();
    idx = 0;
    for (int c = 0; c < 300 && m_phase != P_WAIT; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = words[(idx < TOTAL) ? idx : TOTAL - 1];
      hs = bus.in_valid && (m_phase == P_LOAD);
      cycle_chk("gap_cycle");
      if (hs) idx++;
    end
    check_int("gap_reached_wait", int'(m_phase == P_WAIT), 1);
    bus.in_valid = 1;
    cycle_chk("gap_after");
    cycle_chk("gap_after");
    bus.in_valid = 0;
    check_int("gap_beat_count", got.size(), TOTAL);
    for (int i = 0; i < TOTAL && i < got.size(); i++)
      check($sformatf("gap_beat%0d", i), {7'b0, got[i]}, {7'b0, words[i]});

    // Refresh: rnd_ready drops 2 cycles after the request and returns 5 cycles later
    bus.rnd_ready = 1;
    cycle_chk("rf_to_ready");
    bus.refresh_req = 1;
    cycle_chk("rf_req");
    ppr_cnt = int'(bus.pre_pre_refresh);
    bus.refresh_req = 0;
    for (int t = 1; t <= 10; t++) begin
      bus.rnd_ready = !(t >= 2 && t < 7);
      cycle_chk("rf_seq");
      ppr_cnt += int'(bus.pre_pre_refresh);
    end
    check_int("rf_pulse_count", ppr_cnt, 1);
    check_int("rf_key_ready_end", int'(bus.key_ready), 1);

    // Randomised stimulus against the reference model
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.start       = ($urandom_range(0, 99) < 4);
      bus.in_valid    = ($urandom_range(0, 99) < 60);
      bus.in_data     = $urandom;
      bus.refresh_req = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 20) bus.rnd_ready = ~bus.rnd_ready;
      cycle_chk("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
